music_sequencer: RTL
====================

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter BEAT_LEN, default 512: beats per song, range 2..4096.
REQ-002 Parameter NUM_SONGS, default 4: number of selectable songs, range 1..4.
REQ-003 Parameter TICK_DIV, default 12500000: clk cycles per beat, minimum 2.
REQ-004 clk  input  1  system clock; all logic on its rising edge; one clock only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 play  input  1  single-cycle pulse: start, pause or resume.
REQ-007 stop  input  1  single-cycle pulse: stop and rewind.
REQ-008 next  input  1  single-cycle pulse: select the next song.
REQ-009 prev  input  1  single-cycle pulse: select the previous song.
REQ-010 ibeat  output  12  current beat index, registered.
REQ-011 song_sel  output  2  current song index, registered.
REQ-012 state  output  2  FSM state: STOP=0, PLAY=1, PAUSE=2, DONE=3.
REQ-013 playing  output  1  high exactly when state==PLAY.
REQ-014 song_done  output  1  one-cycle pulse at end of song.

Function
REQ-015 Internal tick counter SHALL count 0..TICK_DIV-1 only in PLAY, hold in PAUSE, and read 0 in STOP and DONE.
REQ-016 A beat tick SHALL occur in the cycle the counter equals TICK_DIV-1; on the next edge the counter returns to 0 and ibeat advances by 1.
REQ-017 Command priority SHALL be stop > next/prev > play; a beat tick in the same cycle as any accepted command SHALL be discarded.
REQ-018 stop in any state SHALL go to STOP with ibeat=0 and counter=0; song_sel is unchanged.
REQ-019 play SHALL move STOP->PLAY, PLAY->PAUSE, PAUSE->PLAY (ibeat and counter preserved) and DONE->PLAY (ibeat=0, counter=0).
REQ-020 next SHALL set song_sel=(song_sel+1) mod NUM_SONGS; prev SHALL set song_sel=(song_sel+NUM_SONGS-1) mod NUM_SONGS.
REQ-021 An accepted next or prev SHALL also zero ibeat and the counter. PLAY and PAUSE are kept; DONE goes to STOP; STOP stays STOP.
REQ-022 next and prev asserted together SHALL both be ignored; a play in the same cycle is then evaluated normally.
REQ-023 A beat tick with ibeat==BEAT_LEN-1 SHALL be end-of-song: song_done pulses for one cycle, aligned with the resulting state and ibeat update.
REQ-024 Outputs SHALL change only on clk edges; playing and song_done are registered; command-to-output latency is one cycle.
REQ-025 DONE SHALL hold ibeat and song_sel; it is left only by play, stop, next or prev.

Reset
REQ-026 reset SHALL override all inputs. On the next edge: state=STOP, ibeat=0, song_sel=0, counter=0, playing=0, song_done=0.
REQ-027 reset asserted mid-song or mid-pause SHALL abandon the position; no song_done is generated.

Configuration
REQ-028 Macro SEQ_AUTONEXT_EN compiled in: at end-of-song the block SHALL set ibeat=0 and song_sel=(song_sel+1) mod NUM_SONGS, and stay in PLAY.
REQ-029 Macro SEQ_AUTONEXT_EN absent: at end-of-song the block SHALL enter DONE with ibeat held at BEAT_LEN-1; song_done pulses in both builds.

Verification (TICK_DIV=4, BEAT_LEN=8, NUM_SONGS=4)
REQ-030 reset, then play pulse -> state=1 next cycle; ibeat=1 after 4 more cycles, ibeat=2 after 8.
REQ-031 Play to ibeat=3, play pulse, idle 20 cycles, play pulse -> ibeat stays 3 while state=2; the counter resumes from its held value.
REQ-032 Play to the end, macro absent -> song_done=1 for one cycle, state=3, ibeat=7; a play pulse then gives state=1, ibeat=0.
REQ-033 Same run, macro present -> song_done pulse, ibeat=0, song_sel=1, state=1; repeating from song_sel=3 wraps to 0.
REQ-034 At song_sel=0, prev pulse -> song_sel=3. next and prev together -> no change. stop with next in a PLAY beat-tick cycle -> state=0, ibeat=0, song_sel unchanged.
REQ-035 Assert reset during PAUSE at ibeat=5, song_sel=2 -> all outputs zero the next cycle, state=0.

Source files
------------

// File: rtl/music_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : music_sequencer
// Description : Beat-based song sequencer with play/pause/stop transport and
//               next/prev song selection. A prescaler divides clk into beat
//               ticks; ibeat walks 0..BEAT_LEN-1 through the selected song.
//               Optional build macro SEQ_AUTONEXT_EN: at end of song, advance
//               to the next song and keep playing instead of entering DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module music_sequencer #(
  parameter int BEAT_LEN  = 512,
  parameter int NUM_SONGS = 4,
  parameter int TICK_DIV  = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        stop,
  input  logic        next,
  input  logic        prev,
  output logic [11:0] ibeat,
  output logic [1:0]  song_sel,
  output logic [1:0]  state,
  output logic        playing,
  output logic        song_done
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int               c_CNT_W     = $clog2(TICK_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [11:0]      c_BEAT_LAST = 12'(BEAT_LEN - 1);
  localparam logic [1:0]       c_SONG_LAST = 2'(NUM_SONGS - 1);

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_sel_cmd;
  logic                 w_tick;
  logic [1:0]           w_song_inc;
  logic [1:0]           w_song_dec;

  assign state = r_state;

  // Exactly one of next/prev is a song-select command; both together cancel.
  assign w_sel_cmd = next ^ prev;
  assign w_tick    = (r_state == ST_PLAY) && (r_cnt == c_CNT_LAST);

  // Modulo-NUM_SONGS neighbours of the current song.
  always_comb begin
    w_song_inc = (song_sel == c_SONG_LAST) ? 2'd0 : song_sel + 2'd1;
    w_song_dec = (song_sel == 2'd0) ? c_SONG_LAST : song_sel - 2'd1;
  end

  // Transport FSM with prescaler and beat position; command priority is
  // stop > next/prev > play, and any accepted command swallows a beat tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_STOP;
      r_cnt     <= '0;
      ibeat     <= 12'd0;
      song_sel  <= 2'd0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (stop) begin
        r_state <= ST_STOP;
        playing <= 1'b0;
        ibeat   <= 12'd0;
        r_cnt   <= '0;
      end else if (w_sel_cmd) begin
        song_sel <= next ? w_song_inc : w_song_dec;
        ibeat    <= 12'd0;
        r_cnt    <= '0;
        // PLAY and PAUSE are kept, so playing is already correct.
        if (r_state == ST_DONE) begin
          r_state <= ST_STOP;
          playing <= 1'b0;
        end
      end else if (play) begin
        case (r_state)
          ST_STOP: begin
            r_state <= ST_PLAY;
            playing <= 1'b1;
          end
          ST_PLAY: begin
            r_state <= ST_PAUSE;
            playing <= 1'b0;
          end
          ST_PAUSE: begin
            r_state <= ST_PLAY;
            playing <= 1'b1;
          end
          default: begin
            r_state <= ST_PLAY;
            playing <= 1'b1;
            ibeat   <= 12'd0;
            r_cnt   <= '0;
          end
        endcase
      end else if (r_state == ST_PLAY) begin
        if (w_tick) begin
          r_cnt <= '0;
          if (ibeat == c_BEAT_LAST) begin
            song_done <= 1'b1;
`ifdef SEQ_AUTONEXT_EN
            ibeat    <= 12'd0;
            song_sel <= w_song_inc;
`else
            r_state  <= ST_DONE;
            playing  <= 1'b0;
`endif
          end else begin
            ibeat <= ibeat + 12'd1;
          end
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire
